parallel_target: RTL and testbench
==================================

Name: parallel_target

Overview:
- Device-side responder for the asynchronous parallel SRAM-style interface (address, 32-bit data, ce_n/oe_n/we_n).
- Lets an external or bridged parallel initiator access an internal stalling bus.
- Synchronizes the strobes into clk_bus and converts each strobe cycle into exactly one internal read or write request.
- Returns read data on the parallel data pins.

Parameters:
- SYNC_STAGES, 2: flop depth of the strobe/address/data synchronizer; legal values 2..3.
- TIMEOUT, 16: maximum cycles a request may stall before it is aborted; legal values 1..255.
- ERR_DATA, 32'hDEADBEEF: read data returned after a timeout.

Ports:
- clk_bus  in  1  bus clock
- rst  in  1  synchronous active-high reset
- dev_address  in  24  parallel address
- dev_data_i  in  32  parallel data from the pins (pad input)
- dev_data_o  out  32  read data toward the pins
- dev_data_oe  out  1  pad output enable for dev_data_o
- dev_we_n  in  1  write strobe, active low
- dev_oe_n  in  1  output-enable strobe, active low
- dev_ce_n  in  1  chip enable, active low
- mem_address  out  24  internal request address
- mem_data_o  out  32  internal write data
- mem_data_i  in  32  internal read data
- mem_read  out  1  internal read request
- mem_write  out  1  internal write request
- mem_stall  in  1  internal stall; a request completes in the first cycle it is high with mem_stall low
- err_timeout  out  1  one-cycle pulse when a request is aborted

Behaviour:
- One clock (clk_bus). Reset is synchronous and active-high: rst is sampled only on the clk_bus rising edge.
- Reset values: mem_read=0, mem_write=0, mem_address=0, mem_data_o=0, dev_data_o=0, dev_data_oe=0, err_timeout=0, state=IDLE, timeout counter=0, all synchronizer flops=1 for strobes and 0 for address/data.
- Synchronizer:
  - ce_n, we_n and oe_n each pass through SYNC_STAGES flops.
  - dev_address and dev_data_i pass through an equal-depth pipeline so they stay aligned with the strobes.
  - All decisions below use the synchronized values (s_ce, s_we, s_oe are active-high versions).
- States:
  - IDLE: if s_ce&s_we, go to WR_CAPT (write has priority over a simultaneous s_oe). Else if s_ce&s_oe, latch the address into mem_address, assert mem_read, go to RD_REQ.
  - WR_CAPT: every cycle that s_ce&s_we holds, latch the aligned address and data into mem_address/mem_data_o. When s_we or s_ce deasserts (end of write = first rising strobe), assert mem_write and go to WR_REQ. Values latched in the last active cycle are written.
  - WR_REQ: hold mem_write until completion, then deassert and go to WAIT_IDLE.
  - RD_REQ: hold mem_read until completion; on completion latch mem_data_i into dev_data_o and go to RD_DRIVE. If s_ce or s_oe deasserts first, still finish the internal read but discard the data and go to WAIT_IDLE.
  - RD_DRIVE: stay while s_ce&s_oe, then go to IDLE. A new address while strobes stay low is not re-read; the initiator must toggle ce_n or oe_n for each access.
  - WAIT_IDLE: go to IDLE once both s_we and s_oe are inactive or s_ce is inactive.
- dev_data_oe = (state==RD_DRIVE) & ~dev_oe_n & ~dev_ce_n & dev_we_n, using the raw pins combinationally so the pads release immediately on strobe deassertion.
- Timeout:
  - An 8-bit counter clears on entry to RD_REQ/WR_REQ and increments each stalled cycle.
  - Reaching TIMEOUT drops the request and pulses err_timeout.
  - On a read timeout, dev_data_o=ERR_DATA and the state goes to RD_DRIVE (or WAIT_IDLE if the strobes are gone). On a write timeout, go to WAIT_IDLE.
- Latency with mem_stall=0:
  - Raw oe_n/ce_n fall to mem_read high: SYNC_STAGES+1 cycles.
  - Then dev_data_oe rises 1 cycle later.
  - The system requires the initiator strobe hold to be at least SYNC_STAGES+3 cycles.
- Exactly one internal request per strobe cycle; mem_read and mem_write are never high together.
- Reset mid-operation: any pending request is dropped without completion, outputs return to reset values, and the block waits in IDLE for fresh strobes.

Test Plan:
- Write: ce_n=0, we_n=0, address 24'h000010, data 32'hA5A5_1234 for 5 cycles, then strobes high, mem_stall=0 -> exactly one mem_write pulse with mem_address=24'h000010, mem_data_o=32'hA5A51234, no mem_read.
- Read: ce_n=0, oe_n=0, address 24'h000020, mem_data_i=32'h0BAD_F00D, mem_stall=0 -> mem_read high 3 cycles after strobe fall for 1 cycle; dev_data_oe=1 with dev_data_o=32'h0BADF00D the next cycle; dev_data_oe=0 in the same cycle oe_n rises.
- Stall: read with mem_stall high 4 cycles -> mem_read held 5 cycles, data returned; err_timeout stays 0.
- Timeout: TIMEOUT=16, mem_stall stuck high during a read -> mem_read drops after 16 cycles, err_timeout pulses once, dev_data_o=32'hDEADBEEF.
- Priority/abort: oe_n and we_n low together -> write only, no mem_read. Read with ce_n released before completion -> dev_data_oe never asserts.
- Reset: rst=1 while in WR_REQ -> next cycle mem_write=0 and all outputs at reset values; a subsequent write completes normally.

Source files
------------

// File: rtl/parallel_target.sv
// parallel_target: device-side responder for an asynchronous SRAM-style
// parallel port (ce_n/oe_n/we_n strobes, 24-bit address, 32-bit data).
// Strobes, address and data are resynchronized into clk_bus through
// equal-depth pipelines. Each strobe cycle becomes exactly one internal
// read or write request on a stalling bus. A request that stalls too long
// is aborted, and err_timeout pulses for one cycle.
module parallel_target #(
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT     = 16,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic        clk_bus,
  input  logic        rst,
  input  logic [23:0] dev_address,
  input  logic [31:0] dev_data_i,
  output logic [31:0] dev_data_o,
  output logic        dev_data_oe,
  input  logic        dev_we_n,
  input  logic        dev_oe_n,
  input  logic        dev_ce_n,
  output logic [23:0] mem_address,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_stall,
  output logic        err_timeout
);

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_CAPT,
    WR_REQ,
    RD_REQ,
    RD_DRIVE,
    WAIT_IDLE
  } state_t;

  // ---------------------------------------------------------------
  // Synchronizer taps: stage gi output, one entry per stage
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0] ce_n_tap;
  logic [SYNC_STAGES-1:0] we_n_tap;
  logic [SYNC_STAGES-1:0] oe_n_tap;
  logic [23:0]            addr_tap [SYNC_STAGES];
  logic [31:0]            data_tap [SYNC_STAGES];

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    logic        ce_n_src, we_n_src, oe_n_src;
    logic [23:0] addr_src;
    logic [31:0] data_src;
    logic        ce_n_q, we_n_q, oe_n_q;
    logic [23:0] addr_q;
    logic [31:0] data_q;

    if (gi == 0) begin : g_first
      assign ce_n_src = dev_ce_n;
      assign we_n_src = dev_we_n;
      assign oe_n_src = dev_oe_n;
      assign addr_src = dev_address;
      assign data_src = dev_data_i;
    end else begin : g_rest
      assign ce_n_src = ce_n_tap[gi-1];
      assign we_n_src = we_n_tap[gi-1];
      assign oe_n_src = oe_n_tap[gi-1];
      assign addr_src = addr_tap[gi-1];
      assign data_src = data_tap[gi-1];
    end

    // One synchronizer stage; strobes reset inactive (high), payload to zero
    always_ff @(posedge clk_bus) begin
      if (rst) begin
        ce_n_q <= 1'b1;
        we_n_q <= 1'b1;
        oe_n_q <= 1'b1;
        addr_q <= '0;
        data_q <= '0;
      end else begin
        ce_n_q <= ce_n_src;
        we_n_q <= we_n_src;
        oe_n_q <= oe_n_src;
        addr_q <= addr_src;
        data_q <= data_src;
      end
    end

    assign ce_n_tap[gi] = ce_n_q;
    assign we_n_tap[gi] = we_n_q;
    assign oe_n_tap[gi] = oe_n_q;
    assign addr_tap[gi] = addr_q;
    assign data_tap[gi] = data_q;
  end

  // Active-high synchronized strobes and the address/data aligned with them
  logic        s_ce, s_we, s_oe;
  logic [23:0] s_addr;
  logic [31:0] s_data;

  assign s_ce   = ~ce_n_tap[SYNC_STAGES-1];
  assign s_we   = ~we_n_tap[SYNC_STAGES-1];
  assign s_oe   = ~oe_n_tap[SYNC_STAGES-1];
  assign s_addr = addr_tap[SYNC_STAGES-1];
  assign s_data = data_tap[SYNC_STAGES-1];

  // ---------------------------------------------------------------
  // Control FSM and request registers
  // ---------------------------------------------------------------
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rd_abort_q, rd_abort_d;   // strobes went away during RD_REQ
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] dev_rdata_q, dev_rdata_d;
  logic        err_q, err_d;

  logic wr_act, rd_act, rd_gone, cnt_expired;

  assign wr_act      = s_ce & s_we;
  assign rd_act      = s_ce & s_oe;
  assign rd_gone     = rd_abort_q | ~rd_act;
  assign cnt_expired = (cnt_q == TIMEOUT_M1);

  // Next-state and request decisions, all from synchronized strobes
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_abort_d  = rd_abort_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dev_rdata_d = dev_rdata_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_act) begin
          // Write wins over a simultaneous output enable
          mem_addr_d  = s_addr;
          mem_wdata_d = s_data;
          state_d     = WR_CAPT;
        end else if (rd_act) begin
          mem_addr_d = s_addr;
          mem_read_d = 1'b1;
          cnt_d      = '0;
          rd_abort_d = 1'b0;
          state_d    = RD_REQ;
        end
      end

      WR_CAPT: begin
        if (wr_act) begin
          // Keep tracking the pins; the last active cycle's values are written
          mem_addr_d  = s_addr;
          mem_wdata_d = s_data;
        end else begin
          mem_write_d = 1'b1;
          cnt_d       = '0;
          state_d     = WR_REQ;
        end
      end

      WR_REQ: begin
        if (!mem_stall) begin
          mem_write_d = 1'b0;
          state_d     = WAIT_IDLE;
        end else if (cnt_expired) begin
          mem_write_d = 1'b0;
          err_d       = 1'b1;
          state_d     = WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      RD_REQ: begin
        if (!rd_act) begin
          rd_abort_d = 1'b1;
        end
        if (!mem_stall) begin
          mem_read_d = 1'b0;
          if (rd_gone) begin
            // Initiator left early: finish internally, drop the data
            state_d = WAIT_IDLE;
          end else begin
            dev_rdata_d = mem_data_i;
            state_d     = RD_DRIVE;
          end
        end else if (cnt_expired) begin
          mem_read_d  = 1'b0;
          err_d       = 1'b1;
          dev_rdata_d = ERR_DATA;
          state_d     = rd_gone ? WAIT_IDLE : RD_DRIVE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      RD_DRIVE: begin
        // Address changes with strobes held are not re-read
        if (!rd_act) begin
          state_d = IDLE;
        end
      end

      WAIT_IDLE: begin
        if ((!s_we && !s_oe) || !s_ce) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any pending request
  always_ff @(posedge clk_bus) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_abort_q  <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dev_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_abort_q  <= rd_abort_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dev_rdata_q <= dev_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_addr_q;
  assign mem_data_o  = mem_wdata_q;
  assign dev_data_o  = dev_rdata_q;
  assign err_timeout = err_q;

  // Pads follow the raw strobes so they release without synchronizer delay
  assign dev_data_oe = (state_q == RD_DRIVE) & ~dev_oe_n & ~dev_ce_n & dev_we_n;

endmodule

// File: tb/tb_parallel_target.sv
// Scoreboard bench for parallel_target: stimulus pushes expected bus events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_parallel_target;

  localparam int K_WR  = 1;  // mem_write completes
  localparam int K_RD  = 2;  // mem_read completes
  localparam int K_DRV = 3;  // dev_data_oe rises
  localparam int K_TO  = 4;  // err_timeout pulse

  logic        clk_bus = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] dev_address = '0;
  logic [31:0] dev_data_i = '0;
  logic [31:0] dev_data_o;
  logic        dev_data_oe;
  logic        dev_we_n = 1'b1;
  logic        dev_oe_n = 1'b1;
  logic        dev_ce_n = 1'b1;
  logic [23:0] mem_address;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i = '0;
  logic        mem_read;
  logic        mem_write;
  logic        mem_stall = 1'b0;
  logic        err_timeout;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int          kind;
    logic [23:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];
  logic oe_prev = 1'b0;

  parallel_target #(
    .SYNC_STAGES(2),
    .TIMEOUT(16),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk_bus(clk_bus),
    .rst(rst),
    .dev_address(dev_address),
    .dev_data_i(dev_data_i),
    .dev_data_o(dev_data_o),
    .dev_data_oe(dev_data_oe),
    .dev_we_n(dev_we_n),
    .dev_oe_n(dev_oe_n),
    .dev_ce_n(dev_ce_n),
    .mem_address(mem_address),
    .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_stall(mem_stall),
    .err_timeout(err_timeout)
  );

  always #5 clk_bus = ~clk_bus;

  task automatic tick();
    @(posedge clk_bus);
    #1;
  endtask

  task automatic push(input int k, input logic [23:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic observe(input int k, input logic [23:0] a, input logic [31:0] d);
    exp_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, required none", k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr !== a || e.data !== d) begin
        mismatched++;
        $display("FAIL event: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                 k, a, d, e.kind, e.addr, e.data);
      end else begin
        $display("event ok kind=%0d addr=%h data=%h @%0t", k, a, d, $time);
      end
    end
  endtask

  // Bounded wait for mem_write (want_write=1) or mem_read (want_write=0)
  task automatic wait_high(input bit want_write, output int cyc);
    cyc = 0;
    while (((want_write ? mem_write : mem_read) !== 1'b1) && cyc < 60) begin
      tick();
      cyc++;
    end
    if (cyc >= 60) begin
      compared++;
      mismatched++;
      $display("FAIL wait_request: got no request in 60 cycles, required one");
    end
  endtask

  task automatic strobes(input logic ce, input logic we, input logic oe);
    dev_ce_n = ce;
    dev_we_n = we;
    dev_oe_n = oe;
  endtask

  // Monitor: one compare per DUT-presented event
  initial begin
    forever begin
      @(negedge clk_bus);
      if (rst) begin
        oe_prev = 1'b0;
      end else begin
        if (mem_read && mem_write) begin
          compared++;
          mismatched++;
          $display("FAIL read_write_overlap: got both high, required at most one");
        end
        if (err_timeout) observe(K_TO, 24'h0, 32'h0);
        if (mem_write && !mem_stall) observe(K_WR, mem_address, mem_data_o);
        if (mem_read && !mem_stall) observe(K_RD, mem_address, 32'h0);
        if (dev_data_oe && !oe_prev) observe(K_DRV, 24'h0, dev_data_o);
        oe_prev = dev_data_oe;
      end
    end
  end

  // Stimulus
  initial begin
    int cyc;
    int hi;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_address", 32'(mem_address), 32'h0);
    chk("rst_mem_data_o", mem_data_o, 32'h0);
    chk("rst_dev_data_o", dev_data_o, 32'h0);
    chk("rst_dev_data_oe", 32'(dev_data_oe), 32'h0);
    chk("rst_err_timeout", 32'(err_timeout), 32'h0);

    // Write: 5-cycle strobe, pins changed to junk on release
    push(K_WR, 24'h000010, 32'hA5A51234);
    strobes(1'b0, 1'b0, 1'b1);
    dev_address = 24'h000010;
    dev_data_i  = 32'hA5A51234;
    repeat (5) tick();
    strobes(1'b1, 1'b1, 1'b1);
    dev_address = 24'hFFFFFF;
    dev_data_i  = 32'hFFFFFFFF;
    wait_high(1'b1, cyc);
    chk("wr_latency", 32'(cyc), 32'd3);
    tick();
    chk("wr_pulse_width", 32'(mem_write), 32'h0);
    repeat (6) tick();

    // Read with no stall: latency and immediate pad release
    push(K_RD, 24'h000020, 32'h0);
    push(K_DRV, 24'h0, 32'h0BADF00D);
    mem_data_i  = 32'h0BADF00D;
    dev_address = 24'h000020;
    strobes(1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk("rd_early", 32'(mem_read), 32'h0);
    tick();
    chk("rd_latency", 32'(mem_read), 32'h1);
    tick();
    chk("rd_pulse_width", 32'(mem_read), 32'h0);
    chk("rd_oe_on", 32'(dev_data_oe), 32'h1);
    chk("rd_data", dev_data_o, 32'h0BADF00D);
    repeat (2) tick();
    dev_oe_n = 1'b1;
    #1;
    chk("rd_oe_release", 32'(dev_data_oe), 32'h0);
    dev_ce_n = 1'b1;
    repeat (6) tick();

    // Read stalled 4 cycles: mem_read held 5
    push(K_RD, 24'h000040, 32'h0);
    push(K_DRV, 24'h0, 32'h12345678);
    mem_data_i  = 32'h12345678;
    mem_stall   = 1'b1;
    dev_address = 24'h000040;
    strobes(1'b0, 1'b1, 1'b0);
    wait_high(1'b0, cyc);
    hi = 1;
    repeat (4) begin
      tick();
      if (mem_read) hi++;
    end
    mem_stall = 1'b0;
    tick();
    if (mem_read) hi++;
    chk("stall_read_cycles", 32'(hi), 32'd5);
    chk("stall_oe_on", 32'(dev_data_oe), 32'h1);
    repeat (2) tick();
    strobes(1'b1, 1'b1, 1'b1);
    repeat (6) tick();

    // Timeout: stall stuck high during a read
    push(K_TO, 24'h0, 32'h0);
    push(K_DRV, 24'h0, 32'hDEADBEEF);
    mem_stall   = 1'b1;
    dev_address = 24'h000050;
    strobes(1'b0, 1'b1, 1'b0);
    wait_high(1'b0, cyc);
    hi = 1;
    for (int i = 0; i < 40 && mem_read; i++) begin
      tick();
      if (mem_read) hi++;
    end
    chk("to_read_cycles", 32'(hi), 32'd16);
    chk("to_err_pulse", 32'(err_timeout), 32'h1);
    chk("to_err_data", dev_data_o, 32'hDEADBEEF);
    tick();
    chk("to_err_one_cycle", 32'(err_timeout), 32'h0);
    strobes(1'b1, 1'b1, 1'b1);
    mem_stall = 1'b0;
    repeat (6) tick();

    // Priority: we_n and oe_n low together -> write only
    push(K_WR, 24'h000030, 32'h11223344);
    dev_address = 24'h000030;
    dev_data_i  = 32'h11223344;
    strobes(1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    strobes(1'b1, 1'b1, 1'b1);
    wait_high(1'b1, cyc);
    repeat (6) tick();

    // Abort: ce_n released before the stalled read completes
    push(K_RD, 24'h000060, 32'h0);
    mem_stall   = 1'b1;
    mem_data_i  = 32'h55555555;
    dev_address = 24'h000060;
    strobes(1'b0, 1'b1, 1'b0);
    wait_high(1'b0, cyc);
    dev_ce_n = 1'b1;
    repeat (4) tick();
    mem_stall = 1'b0;
    tick();
    chk("abort_read_done", 32'(mem_read), 32'h0);
    dev_oe_n = 1'b1;
    repeat (6) tick();
    chk("abort_no_drive", 32'(dev_data_oe), 32'h0);

    // Reset while a write is stalled in WR_REQ
    mem_stall   = 1'b1;
    dev_address = 24'h000070;
    dev_data_i  = 32'hCAFE0001;
    strobes(1'b0, 1'b0, 1'b1);
    repeat (5) tick();
    strobes(1'b1, 1'b1, 1'b1);
    wait_high(1'b1, cyc);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mid_mem_address", 32'(mem_address), 32'h0);
    chk("rst_mid_mem_data_o", mem_data_o, 32'h0);
    chk("rst_mid_dev_data_o", dev_data_o, 32'h0);
    chk("rst_mid_err", 32'(err_timeout), 32'h0);
    rst = 1'b0;
    mem_stall = 1'b0;
    repeat (3) tick();

    // Fresh write after reset
    push(K_WR, 24'h000080, 32'h0F0F0F0F);
    dev_address = 24'h000080;
    dev_data_i  = 32'h0F0F0F0F;
    strobes(1'b0, 1'b0, 1'b1);
    repeat (5) tick();
    strobes(1'b1, 1'b1, 1'b1);
    wait_high(1'b1, cyc);
    repeat (10) tick();

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
